vu_level_detector: RTL and testbench
====================================

Name: vu_level_detector

Overview:
- Upstream of the front-panel VU meter driver.
- Converts the full-width signed L/R audio samples, one pair per 96 kHz audio_clk_enable strobe, into 8-bit meter levels for the front panel's l_audio_signal/r_audio_signal inputs.
- Each channel has an instant-attack / exponential-release envelope, a peak-hold value and a stretched clip indicator.
- Fully pipelined, 2-clock latency, one strobe per clock supported.

Parameters:
- SAMPLE_W, 24: signed input sample width.
- LEVEL_W, 8: output level width, taken as MSBs of the envelope.
- RELEASE_SHIFT, 10: envelope release, env -= env>>RELEASE_SHIFT per sample.
- HOLD_SAMPLES, 9600: peak-hold and clip-stretch duration in strobes (100 ms at 96 kHz).
- CLIP_THRESH, 24'h7FFF00: a rectified magnitude >= this value flags clip.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- audio_clk_enable  in  1  96 kHz sample strobe, one clk wide.
- audio_enable  in  1  1 = music playing; 0 forces input magnitude to 0.
- l_sample  in  SAMPLE_W  left sample, two's complement.
- r_sample  in  SAMPLE_W  right sample, two's complement.
- l_level  out  LEVEL_W  left envelope MSBs, feeds l_audio_signal.
- r_level  out  LEVEL_W  right envelope MSBs, feeds r_audio_signal.
- l_peak  out  LEVEL_W  left peak-hold MSBs.
- r_peak  out  LEVEL_W  right peak-hold MSBs.
- l_clip  out  1  left clip, stretched.
- r_clip  out  1  right clip, stretched.
- level_valid  out  1  one-clk pulse when the outputs update.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on reset_n. Reset clears every register and output: levels, peaks, clip flags, level_valid, env, peak, hold counters, clip counters.
- Rectify (edge E0, where audio_clk_enable = 1):
  - mag = |sample|, registered, unsigned SAMPLE_W-1 bits.
  - Input -2^(SAMPLE_W-1) saturates to 2^(SAMPLE_W-1)-1.
  - audio_enable = 0 forces mag = 0.
  - A stage-1 valid bit is set.
- Envelope update (edge E1, stage-1 valid):
  - If mag > env: env <= mag (instant attack).
  - Otherwise env <= env - (env>>RELEASE_SHIFT).
  - If env != 0 but the shift term is 0, subtract 1, so env always reaches 0.
  - No underflow: env is never below 0.
- Peak hold (edge E1):
  - If mag >= peak: peak <= mag, hold_cnt <= HOLD_SAMPLES-1.
  - Else if hold_cnt != 0: hold_cnt decrements.
  - Else peak <= env. Peak tracks the envelope down and never goes below env.
- Clip (edge E1):
  - If mag >= CLIP_THRESH: clip_cnt <= HOLD_SAMPLES-1 and clip_flag <= 1.
  - Else if clip_cnt != 0: decrement.
  - Else clip_flag <= 0.
- Output (edge E2):
  - l/r_level <= env[MSB -: LEVEL_W].
  - l/r_peak <= peak[MSB -: LEVEL_W].
  - clip outputs registered.
  - level_valid = 1 for exactly one clk.
  - Outputs hold between updates.
- Latency: 2 clk from the capture edge E0 to the output edge E2.
- Throughput: strobes on consecutive clocks are each processed in order; no stalls, no drops.
- Channels are independent and update on the same edges.
- audio_enable falling mid-stream: meters decay at the release rate; no snap to zero.
- reset_n asserted mid-pipeline: in-flight samples are discarded and no level_valid is issued.
- The hold counters count strobes, not clocks.

Decomposition:
- Shared package vu_pkg:
  - localparams for default SAMPLE_W, LEVEL_W, HOLD_SAMPLES.
  - typedef mag_t, unsigned SAMPLE_W-1 bits.
  - typedef hold_cnt_t, $clog2(HOLD_SAMPLES) bits.
- Sub-module vu_envelope_channel: rectify, envelope, peak-hold and clip for one channel, carrying its own valid pipeline.
- Top level: two instances of vu_envelope_channel; level_valid is taken from the left instance.

Test Plan:
- Reset with reset_n = 0 then 1, no strobes:
  - all outputs 0.
  - level_valid never asserts.
- One strobe with l_sample = 24'h7FFFFF, then zeros:
  - level_valid pulses 2 clk after the capture edge.
  - l_level = 8'hFF, l_peak = 8'hFF, l_clip = 1.
  - Next strobe: env = 24'h7FE000, l_level still 8'hFF.
  - r_level stays 0 throughout.
- l_sample = 24'h800000 (most-negative value):
  - mag = 24'h7FFFFF, no wrap to 0.
  - l_level = 8'hFF, l_clip = 1.
- Peak hold: one strobe at 24'h400000 (l_level 8'h80), then zeros:
  - l_peak stays 8'h80 for exactly HOLD_SAMPLES strobes while l_level decays.
  - Next strobe: l_peak equals l_level.
  - l_clip stays 0 throughout.
- Full-scale then audio_enable = 0, with RELEASE_SHIFT = 2 for this test:
  - env reaches exactly 0 after a finite number of strobes.
  - No underflow wrap to 8'hFF.
  - l_clip clears after HOLD_SAMPLES strobes.
- audio_clk_enable held high for 4 consecutive clocks with samples 8'h10, 8'h20, 8'h30, 8'h40 in the top byte:
  - 4 level_valid pulses on 4 consecutive clocks.
  - l_level sequence 8'h20, 8'h40, 8'h60, 8'h80.

Source files
------------

// File: rtl/vu_level_detector_pkg.sv
// Shared defaults and types for the VU meter level detector.
// Sample width, meter width and hold length live here so that both channels and the top agree.
package vu_pkg;

    localparam int VU_SAMPLE_W     = 24;
    localparam int VU_LEVEL_W      = 8;
    localparam int VU_HOLD_SAMPLES = 9600;

    typedef logic [VU_SAMPLE_W-2:0]                 mag_t;
    typedef logic [$clog2(VU_HOLD_SAMPLES)-1:0]     hold_cnt_t;

endpackage

// File: rtl/vu_level_detector_channel.sv
// One meter channel: rectify, attack/release envelope, peak hold and stretched clip.
// Carries its own valid pipeline so the two channels stay in lock-step without sharing state.
module vu_envelope_channel
    import vu_pkg::*;
#(
    parameter int                  SAMPLE_W      = VU_SAMPLE_W,
    parameter int                  LEVEL_W       = VU_LEVEL_W,
    parameter int                  RELEASE_SHIFT = 10,
    parameter int                  HOLD_SAMPLES  = VU_HOLD_SAMPLES,
    parameter logic [SAMPLE_W-1:0] CLIP_THRESH   = SAMPLE_W'(24'h7FFF00)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_vld,
    input  logic                audio_enable,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [LEVEL_W-1:0]  level,
    output logic [LEVEL_W-1:0]  peak,
    output logic                clip,
    output logic                level_vld
);

    localparam int               MAG_W     = SAMPLE_W - 1;
    localparam int               CNT_W     = $clog2(HOLD_SAMPLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_SAMPLES - 1);

    function automatic logic [MAG_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] s);
        logic signed [SAMPLE_W-1:0] a;
        a = (s < 0) ? -s : s;
        // Only the most-negative input still has its sign bit set after negation
        return a[SAMPLE_W-1] ? {MAG_W{1'b1}} : a[MAG_W-1:0];
    endfunction

    function automatic logic [MAG_W-1:0] release_step(input logic [MAG_W-1:0] e);
        logic [MAG_W-1:0] d;
        d = e >> RELEASE_SHIFT;
        if (d == '0 && e != '0)
            d = MAG_W'(1);
        return e - d;
    endfunction

    logic signed [SAMPLE_W-1:0] sample_s;
    logic [MAG_W-1:0]           mag_p0;
    logic                       vld_p0;
    logic [MAG_W-1:0]           env_p1;
    logic [MAG_W-1:0]           peak_p1;
    logic [CNT_W-1:0]           hold_cnt_p1;
    logic [CNT_W-1:0]           clip_cnt_p1;
    logic                       clip_p1;
    logic                       vld_p1;
    logic [MAG_W-1:0]           env_nxt;
    logic                       clip_hit;

    assign sample_s = sample;

    // Stage 0: rectified magnitude capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= sample_vld;
            if (sample_vld)
                mag_p0 <= audio_enable ? sat_abs(sample_s) : '0;
        end
    end

    assign env_nxt  = (mag_p0 > env_p1) ? mag_p0 : release_step(env_p1);
    assign clip_hit = ({1'b0, mag_p0} >= CLIP_THRESH);

    // Stage 1: envelope, peak hold and clip stretch, advanced once per strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env_p1      <= '0;
            peak_p1     <= '0;
            hold_cnt_p1 <= '0;
            clip_cnt_p1 <= '0;
            clip_p1     <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                env_p1 <= env_nxt;
                if (mag_p0 >= peak_p1) begin
                    peak_p1     <= mag_p0;
                    hold_cnt_p1 <= HOLD_LOAD;
                end else if (hold_cnt_p1 != '0) begin
                    hold_cnt_p1 <= hold_cnt_p1 - 1'b1;
                end else begin
                    peak_p1 <= env_nxt;
                end
                if (clip_hit) begin
                    clip_cnt_p1 <= HOLD_LOAD;
                    clip_p1     <= 1'b1;
                end else if (clip_cnt_p1 != '0) begin
                    clip_cnt_p1 <= clip_cnt_p1 - 1'b1;
                end else begin
                    clip_p1 <= 1'b0;
                end
            end
        end
    end

    // Stage 2: meter outputs, held between updates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level     <= '0;
            peak      <= '0;
            clip      <= 1'b0;
            level_vld <= 1'b0;
        end else begin
            level_vld <= vld_p1;
            if (vld_p1) begin
                level <= env_p1[MAG_W-1 -: LEVEL_W];
                peak  <= peak_p1[MAG_W-1 -: LEVEL_W];
                clip  <= clip_p1;
            end
        end
    end

endmodule

// File: rtl/vu_level_detector.sv
// Stereo VU level detector feeding the front-panel meter driver.
// Both channels run the same pipeline on the same strobe; the left one supplies level_valid.
module vu_level_detector
    import vu_pkg::*;
#(
    parameter int                  SAMPLE_W      = VU_SAMPLE_W,
    parameter int                  LEVEL_W       = VU_LEVEL_W,
    parameter int                  RELEASE_SHIFT = 10,
    parameter int                  HOLD_SAMPLES  = VU_HOLD_SAMPLES,
    parameter logic [SAMPLE_W-1:0] CLIP_THRESH   = SAMPLE_W'(24'h7FFF00)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                audio_clk_enable,
    input  logic                audio_enable,
    input  logic [SAMPLE_W-1:0] l_sample,
    input  logic [SAMPLE_W-1:0] r_sample,
    output logic [LEVEL_W-1:0]  l_level,
    output logic [LEVEL_W-1:0]  r_level,
    output logic [LEVEL_W-1:0]  l_peak,
    output logic [LEVEL_W-1:0]  r_peak,
    output logic                l_clip,
    output logic                r_clip,
    output logic                level_valid
);

    logic r_vld_unused;

    vu_envelope_channel #(
        .SAMPLE_W      (SAMPLE_W),
        .LEVEL_W       (LEVEL_W),
        .RELEASE_SHIFT (RELEASE_SHIFT),
        .HOLD_SAMPLES  (HOLD_SAMPLES),
        .CLIP_THRESH   (CLIP_THRESH)
    ) u_left (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_vld   (audio_clk_enable),
        .audio_enable (audio_enable),
        .sample       (l_sample),
        .level        (l_level),
        .peak         (l_peak),
        .clip         (l_clip),
        .level_vld    (level_valid)
    );

    vu_envelope_channel #(
        .SAMPLE_W      (SAMPLE_W),
        .LEVEL_W       (LEVEL_W),
        .RELEASE_SHIFT (RELEASE_SHIFT),
        .HOLD_SAMPLES  (HOLD_SAMPLES),
        .CLIP_THRESH   (CLIP_THRESH)
    ) u_right (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_vld   (audio_clk_enable),
        .audio_enable (audio_enable),
        .sample       (r_sample),
        .level        (r_level),
        .peak         (r_peak),
        .clip         (r_clip),
        .level_vld    (r_vld_unused)
    );

endmodule

// File: tb/tb_vu_level_detector.sv
// Bench for vu_level_detector: two instances (release shift 10 and 2) share one stimulus stream
// and are compared every clock against a per-strobe arithmetic model of the meter rules.
module tb_vu_level_detector;

    localparam int HOLD  = 9600;
    localparam int MAXM  = 8388607;
    localparam int CLIPM = 'h7FFF00;

    typedef struct packed {
        logic                  v;
        logic [1:0][1:0][7:0]  lvl;
        logic [1:0][1:0][7:0]  pk;
        logic [1:0][1:0]       clp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b1;
    logic        stb = 1'b0;
    logic        en = 1'b0;
    logic [23:0] ls = '0;
    logic [23:0] rs = '0;

    logic [1:0][1:0][7:0] lvl;
    logic [1:0][1:0][7:0] pk;
    logic [1:0][1:0]      clp;
    logic [1:0]           vld;

    vu_level_detector #(.RELEASE_SHIFT(10)) u_dut_r10 (
        .clk(clk), .reset_n(reset_n), .audio_clk_enable(stb), .audio_enable(en),
        .l_sample(ls), .r_sample(rs),
        .l_level(lvl[0][0]), .r_level(lvl[0][1]), .l_peak(pk[0][0]), .r_peak(pk[0][1]),
        .l_clip(clp[0][0]), .r_clip(clp[0][1]), .level_valid(vld[0])
    );

    vu_level_detector #(.RELEASE_SHIFT(2)) u_dut_r2 (
        .clk(clk), .reset_n(reset_n), .audio_clk_enable(stb), .audio_enable(en),
        .l_sample(ls), .r_sample(rs),
        .l_level(lvl[1][0]), .r_level(lvl[1][1]), .l_peak(pk[1][0]), .r_peak(pk[1][1]),
        .l_clip(clp[1][0]), .r_clip(clp[1][1]), .level_valid(vld[1])
    );

    int   checks = 0;
    int   errors = 0;
    int   m_env[2][2];
    int   m_peak[2][2];
    int   m_hold[2][2];
    int   m_ccnt[2][2];
    bit   m_clip[2][2];
    int   rshift[2] = '{10, 2};
    exp_t pipe0, pipe1, held;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int rect(input logic [23:0] x, input bit e);
        int s, a;
        s = int'($signed(x));
        if (!e) return 0;
        a = (s < 0) ? -s : s;
        return (a > MAXM) ? MAXM : a;
    endfunction

    function automatic exp_t model_step(input logic [23:0] l, input logic [23:0] r, input bit e);
        exp_t res;
        int mag, env, dec;
        res = '0;
        res.v = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                mag = rect(c == 0 ? l : r, e);
                env = m_env[d][c];
                if (mag > env) begin
                    env = mag;
                end else begin
                    dec = env / (2 ** rshift[d]);
                    if (dec == 0 && env > 0) dec = 1;
                    env = env - dec;
                end
                if (mag >= m_peak[d][c]) begin
                    m_peak[d][c] = mag;
                    m_hold[d][c] = HOLD - 1;
                end else if (m_hold[d][c] > 0) begin
                    m_hold[d][c]--;
                end else begin
                    m_peak[d][c] = env;
                end
                if (mag >= CLIPM) begin
                    m_ccnt[d][c] = HOLD - 1;
                    m_clip[d][c] = 1'b1;
                end else if (m_ccnt[d][c] > 0) begin
                    m_ccnt[d][c]--;
                end else begin
                    m_clip[d][c] = 1'b0;
                end
                m_env[d][c]    = env;
                res.lvl[d][c]  = 8'(env / 32768);
                res.pk[d][c]   = 8'(m_peak[d][c] / 32768);
                res.clp[d][c]  = m_clip[d][c];
            end
        end
        return res;
    endfunction

    task automatic check_outputs(input logic v);
        for (int d = 0; d < 2; d++) begin
            chk("level_valid", d, 32'(vld[d]), 32'(v));
            for (int c = 0; c < 2; c++) begin
                chk(c ? "r_level" : "l_level", d, 32'(lvl[d][c]), 32'(held.lvl[d][c]));
                chk(c ? "r_peak" : "l_peak", d, 32'(pk[d][c]), 32'(held.pk[d][c]));
                chk(c ? "r_clip" : "l_clip", d, 32'(clp[d][c]), 32'(held.clp[d][c]));
            end
        end
    endtask

    task automatic tick(input bit s, input bit e, input logic [23:0] l, input logic [23:0] r);
        exp_t cur, outp;
        stb = s; en = e; ls = l; rs = r;
        cur = '0;
        if (s && reset_n) cur = model_step(l, r, e);
        @(posedge clk);
        #1;
        outp  = pipe1;
        pipe1 = pipe0;
        pipe0 = cur;
        if (outp.v) begin
            held.lvl = outp.lvl;
            held.pk  = outp.pk;
            held.clp = outp.clp;
        end
        check_outputs(outp.v);
    endtask

    task automatic do_reset();
        stb = 1'b0;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                m_env[d][c] = 0; m_peak[d][c] = 0; m_hold[d][c] = 0;
                m_ccnt[d][c] = 0; m_clip[d][c] = 1'b0;
            end
        pipe0 = '0; pipe1 = '0; held = '0;
        check_outputs(1'b0);
        tick(0, 0, '0, '0);
        tick(0, 0, '0, '0);
        reset_n = 1'b1;
    endtask

    function automatic logic [23:0] pick();
        case ($urandom_range(0, 5))
            0:       return 24'h800000;
            1:       return 24'h7FFFFF;
            2:       return 24'h7FFF00;
            3:       return 24'h800100;
            4:       return 24'($urandom_range(0, 4095));
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        int n_pk[2];
        int n_cl[2];
        int z_idx;
        int n_wrap;

        #2;
        do_reset();
        repeat (5) tick(0, 1, '0, '0);

        // full-scale strobe, then zero strobes
        tick(1, 1, 24'h7FFFFF, 24'h000000);
        tick(0, 1, '0, '0);
        chk("latency_early", 0, 32'(vld[0]), 32'd0);
        tick(0, 1, '0, '0);
        chk("fs_valid", 0, 32'(vld[0]), 32'd1);
        chk("fs_l_level", 0, 32'(lvl[0][0]), 32'hFF);
        chk("fs_l_peak", 0, 32'(pk[0][0]), 32'hFF);
        chk("fs_l_clip", 0, 32'(clp[0][0]), 32'd1);
        chk("fs_r_level", 0, 32'(lvl[0][1]), 32'd0);
        tick(1, 1, '0, '0);
        tick(0, 1, '0, '0);
        tick(0, 1, '0, '0);
        chk("rel_l_level", 0, 32'(lvl[0][0]), 32'hFF);
        chk("rel_l_level", 1, 32'(lvl[1][0]), 32'hC0);
        chk("rel_r_level", 0, 32'(lvl[0][1]), 32'd0);
        repeat (10) tick(1, 1, '0, '0);

        // most-negative input saturates instead of wrapping
        do_reset();
        tick(1, 1, 24'h800000, 24'h800000);
        tick(0, 1, '0, '0);
        tick(0, 1, '0, '0);
        chk("neg_l_level", 0, 32'(lvl[0][0]), 32'hFF);
        chk("neg_l_clip", 0, 32'(clp[0][0]), 32'd1);
        chk("neg_r_level", 0, 32'(lvl[0][1]), 32'hFF);

        // peak hold
        do_reset();
        tick(1, 1, 24'h400000, 24'h000000);
        n_pk = '{0, 0};
        n_cl = '{0, 0};
        for (int i = 0; i < HOLD + 22; i++) begin
            tick(i < HOLD + 20, 1, '0, '0);
            if (i == 1) chk("hold_l_level", 0, 32'(lvl[0][0]), 32'h80);
            for (int d = 0; d < 2; d++) begin
                if (vld[d] && pk[d][0] == 8'h80) n_pk[d]++;
                if (vld[d] && clp[d][0]) n_cl[d]++;
            end
        end
        chk("hold_count", 0, 32'(n_pk[0]), 32'(HOLD));
        chk("hold_count", 1, 32'(n_pk[1]), 32'(HOLD));
        chk("hold_no_clip", 0, 32'(n_cl[0]), 32'd0);

        // full scale, then audio_enable low: decay to zero, clip stretch expires
        do_reset();
        tick(1, 1, 24'h7FFFFF, 24'h7FFFFF);
        n_cl = '{0, 0};
        z_idx = -1;
        n_wrap = 0;
        for (int i = 0; i < HOLD + 22; i++) begin
            tick(i < HOLD + 20, 0, 24'($urandom), 24'($urandom));
            for (int d = 0; d < 2; d++)
                if (vld[d] && clp[d][0]) n_cl[d]++;
            if (vld[1]) begin
                if (z_idx < 0 && lvl[1][0] == 8'h00) z_idx = i;
                else if (z_idx >= 0 && lvl[1][0] != 8'h00) n_wrap++;
            end
        end
        chk("clip_stretch", 0, 32'(n_cl[0]), 32'(HOLD));
        chk("clip_stretch", 1, 32'(n_cl[1]), 32'(HOLD));
        chk("decay_to_zero", 1, 32'(z_idx >= 0 && z_idx < 200), 32'd1);
        chk("no_wrap", 1, 32'(n_wrap), 32'd0);
        chk("decay_end_level", 0, 32'(lvl[0][0]), 32'd0);

        // back-to-back strobes
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(i < 4, 1, 24'((i + 1) << 20), 24'((4 - i) << 20));
            if (i >= 2) begin
                chk("b2b_valid", i, 32'(vld[0]), 32'd1);
                chk("b2b_l_level", i, 32'(lvl[0][0]), 32'((i - 1) * 32));
            end
        end
        tick(0, 1, '0, '0);
        chk("b2b_valid_end", 0, 32'(vld[0]), 32'd0);

        // reset while samples are in flight
        tick(1, 1, 24'h7FFFFF, 24'h7FFFFF);
        do_reset();
        repeat (3) tick(0, 1, '0, '0);
        chk("flush_l_level", 0, 32'(lvl[0][0]), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, pick(), pick());
            if (i == 1500) do_reset();
        end
        repeat (3) tick(0, 1, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
